mux_scan_seq: RTL and testbench
===============================

# mux_scan_seq

Sequencer that sits directly upstream of the 4:1 `mux` and drives its select lines `s0`/`s1`. It steps through the four mux channels, waits a programmable settle time on each, samples the mux `out` back, and presents a 4-bit snapshot with a start/done handshake. Downstream logic sees one parallel word per scan instead of four separately selected bits.

## Interface
- `SETTLE`, default 2: cycles spent on each channel. Legal range 1..15. The channel is sampled on the last cycle.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  scan request. Sampled only in IDLE.
- `mux_out`  in  1  mux `out`, fed back.
- `s0`  out  1  mux select, MSB of the channel index.
- `s1`  out  1  mux select, LSB of the channel index.
- `busy`  out  1  high while a scan is in progress (SETTLE state).
- `done`  out  1  one-cycle pulse: `data` has just been updated.
- `data`  out  4  snapshot. Bit k holds channel k's value, where k = {s0,s1}. This matches the mux decode: i0=00, i1=01, i2=10, i3=11.

## Operation
- The state machine has three states: IDLE, SETTLE, DONE.
- Registers:
  - `ch[1:0]`: channel index.
  - `cnt[3:0]`: settle counter.
  - `shadow[3:0]`: samples collected during the scan.
  - `data[3:0]`, `busy`, `done`.
- `{s0,s1} = ch`, taken straight from the register with no combinational path from `start`.
- **IDLE:** `ch`=0 and `busy`=0. When `start` is 1: go to SETTLE, set `ch`←0, `cnt`←SETTLE-1, clear `shadow`.
- **SETTLE:** `busy`=1.
  - If `cnt`≠0: `cnt`←`cnt`-1.
  - If `cnt`=0: `shadow[ch]`←`mux_out`.
  - After that sample, if `ch`=3: go to DONE, set `data`←{`mux_out`,`shadow[2:0]`} and `ch`←0.
  - Otherwise: `ch`←`ch`+1 and `cnt`←SETTLE-1.
- **DONE:** lasts exactly one cycle, with `done`=1 and `busy`=0, then returns to IDLE unconditionally.
- `start` is ignored in SETTLE and DONE. It is not queued.
- `data` holds its value from one `done` until the next `done` or reset.

## Timing
- Reset values, after the synchronous reset edge:
  - state IDLE.
  - `ch`=0, `cnt`=0, `shadow`=0.
  - `data`=4'b0000.
  - `s0`=`s1`=0.
  - `busy`=0, `done`=0.
- Reset overrides `start` and aborts a scan in progress. The partial `shadow` is discarded and `data` is cleared.
- Latency: let E0 be the edge that accepts `start`.
  - Channel k is selected from E0+k·SETTLE to E0+(k+1)·SETTLE.
  - Channel k is sampled at edge E0+(k+1)·SETTLE.
  - `done` is high in the cycle following edge E0+4·SETTLE.
- Back-to-back: `start` held high is accepted in the IDLE cycle immediately after DONE. The scan period is therefore 4·SETTLE+2 cycles.
- With SETTLE=1 each channel is selected for exactly one cycle.
- `mux_out` must be stable within SETTLE cycles of a select change. The block does not check this.

## Configuration
- Macro `MUX_SCAN_MASK_EN`.
- **Defined:**
  - Adds the input port `mask`, `in 4`, placed after `mux_out`. Bit k=1 skips channel k.
  - `mask` is latched at the start edge.
  - Masked channels take zero cycles and their `data` bit is 0.
  - `ch` advances to the next unmasked index.
  - DONE is entered at edge E0+SETTLE·N, where N is the number of unmasked channels.
  - If `mask`=4'b1111, DONE is entered at E0 itself: `done` is high in the next cycle, `data`=0, and `busy` never asserts.
- **Undefined:** there is no `mask` port and all four channels are always scanned.

## Test plan
- Reset mid-scan: with SETTLE=2, assert `rst` three cycles after `start` → next cycle IDLE, `s0`=`s1`=0, `data`=0, no `done` pulse.
- Full scan: SETTLE=2, mux inputs i0..i3=1,0,1,1, pulse `start` → `{s0,s1}` sequence 00,00,01,01,10,10,11,11. `done` is high in cycle 9 after E0, `data`=4'b1101, `busy` is high for cycles 1-8.
- SETTLE=1, inputs i0..i3=0,1,1,0 → `done` 4 cycles after E0, `data`=4'b0110.
- `start` held high continuously with SETTLE=2, inputs changing between scans → `done` pulses every 10 cycles, each `data` matches the inputs of its scan, `start` is ignored while `busy`.
- `MUX_SCAN_MASK_EN` with `mask`=4'b0101 and all inputs 1, SETTLE=3 → channels 1 and 3 visited for 3 cycles each, `done` 6 cycles after E0, `data`=4'b1010. With `mask`=4'b1111 → `done` the cycle after E0, `data`=0.

Source files
------------

// File: rtl/mux_scan_seq_if.sv
// Bundle between mux_scan_seq and its neighbours: scan request, mux feedback,
// mux selects and snapshot handshake. MUX_SCAN_MASK_EN adds the mask input.
interface mux_scan_seq_if;
  logic       start;
  logic       mux_out;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0] mask;
`endif
  logic       s0;
  logic       s1;
  logic       busy;
  logic       done;
  logic [3:0] data;

  modport master (
    output start,
    output mux_out,
`ifdef MUX_SCAN_MASK_EN
    output mask,
`endif
    input  s0,
    input  s1,
    input  busy,
    input  done,
    input  data
  );

  modport slave (
    input  start,
    input  mux_out,
`ifdef MUX_SCAN_MASK_EN
    input  mask,
`endif
    output s0,
    output s1,
    output busy,
    output done,
    output data
  );
endinterface

// File: rtl/mux_scan_seq.sv
// Scans a 4:1 mux via s0/s1, settles SETTLE cycles per channel, returns a
// 4-bit snapshot with start/busy/done. Ports: clk, rst (sync, active high),
// bus (slave: start, mux_out, [mask], s0, s1, busy, done, data).
// Option: MUX_SCAN_MASK_EN adds bus.mask (bit k=1 skips channel k).
module mux_scan_seq #(
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_scan_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ch;
  logic [3:0] r_cnt;
  logic [3:0] r_shadow;
  logic [3:0] r_data;

  logic [3:0] w_mask_new;
  logic [3:0] w_mask_cur;
  logic [3:0] w_rest;
  logic [1:0] w_first;
  logic [1:0] w_nxt;
  logic       w_none;
  logic       w_last;
  logic       w_sample;
  logic [3:0] w_shadow_nxt;
  logic       w_busy;
  logic       w_done;

  function automatic logic [1:0] f_lsb(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

`ifdef MUX_SCAN_MASK_EN
  logic [3:0] r_mask;

  assign w_mask_new = bus.mask;
  assign w_mask_cur = r_mask;

  // mask is frozen for the whole scan at the accepting edge
  always_ff @(posedge clk) begin
    if (rst)
      r_mask <= '0;
    else if (r_state == S_IDLE && bus.start)
      r_mask <= bus.mask;
  end
`else
  assign w_mask_new = 4'b0000;
  assign w_mask_cur = 4'b0000;
`endif

  // unmasked channels strictly above the current one
  assign w_rest   = ~w_mask_cur & (4'b1110 << r_ch);
  assign w_last   = (w_rest == 4'b0000);
  assign w_nxt    = f_lsb(w_rest);
  assign w_first  = f_lsb(~w_mask_new);
  assign w_none   = &w_mask_new;
  assign w_sample = (r_cnt == 4'd0);

  always_comb begin
    w_shadow_nxt       = r_shadow;
    w_shadow_nxt[r_ch] = bus.mux_out;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.start)
          w_state_nxt = w_none ? S_DONE : S_SETTLE;
      S_SETTLE:
        if (w_sample && w_last)
          w_state_nxt = S_DONE;
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_SETTLE: w_busy = 1'b1;
      S_DONE:   w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch     <= 2'd0;
      r_cnt    <= 4'd0;
      r_shadow <= 4'd0;
      r_data   <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (bus.start) begin
            r_ch     <= w_none ? 2'd0 : w_first;
            r_cnt    <= CNT_INIT;
            r_shadow <= 4'd0;
            if (w_none)
              r_data <= 4'd0;
          end
        S_SETTLE:
          if (!w_sample) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_shadow <= w_shadow_nxt;
            if (w_last) begin
              r_data <= w_shadow_nxt;
              r_ch   <= 2'd0;
            end else begin
              r_ch  <= w_nxt;
              r_cnt <= CNT_INIT;
            end
          end
        default: ;
      endcase
    end
  end

  assign bus.s0   = r_ch[1];
  assign bus.s1   = r_ch[0];
  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.data = r_data;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq: three instances (SETTLE 2, 1, 3),
// behavioural mux feedback and a scan-level reference model.
module tb_mux_scan_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] st;
  logic [3:0] in_v   [3];
  logic [1:0] sel_v  [3];
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [3:0] data_v [3];
  logic [3:0] exp_data [3];
`ifdef MUX_SCAN_MASK_EN
  logic [3:0] mk_v [3];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    mux_scan_seq_if bus();
    mux_scan_seq #(.SETTLE(S)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.start   = st[g];
    assign bus.mux_out = in_v[g][{bus.s0, bus.s1}];
`ifdef MUX_SCAN_MASK_EN
    assign bus.mask    = mk_v[g];
`endif
    assign sel_v[g]    = {bus.s0, bus.s1};
    assign busy_v[g]   = bus.busy;
    assign done_v[g]   = bus.done;
    assign data_v[g]   = bus.data;
  end

  function automatic int settle_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  // One scan: expected select per cycle is the (t/SETTLE)-th unmasked
  // channel, done after SETTLE*N cycles, data = inputs with masked bits 0.
  task automatic run_scan(input int g, input logic [3:0] v,
                          input logic [3:0] m, input string nm);
    int         s;
    int         n;
    logic [1:0] chs[$];
    logic [3:0] prev;
    s = settle_of(g);
    for (int k = 0; k < 4; k++)
      if (!m[k]) chs.push_back(2'(k));
    n = chs.size();
    prev = exp_data[g];
    in_v[g] = v;
`ifdef MUX_SCAN_MASK_EN
    mk_v[g] = m;
`endif
    st[g] = 1'b1;
    @(posedge clk); #1;
    st[g] = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    mk_v[g] = ~m;
`endif
    for (int t = 0; t < s * n; t++) begin
      n_chk++;
      if (sel_v[g] !== chs[t / s] || busy_v[g] !== 1'b1 ||
          done_v[g] !== 1'b0 || data_v[g] !== prev) begin
        n_fail++;
        $display("FAIL %s scan t=%0d: sel=%b busy=%b done=%b data=%b, required sel=%b busy=1 done=0 data=%b",
                 nm, t, sel_v[g], busy_v[g], done_v[g], data_v[g], chs[t / s], prev);
      end
      @(posedge clk); #1;
    end
    exp_data[g] = v & ~m;
    n_chk++;
    if (done_v[g] !== 1'b1 || busy_v[g] !== 1'b0 ||
        data_v[g] !== exp_data[g] || sel_v[g] !== 2'd0) begin
      n_fail++;
      $display("FAIL %s done: done=%b busy=%b data=%b sel=%b, required done=1 busy=0 data=%b sel=00",
               nm, done_v[g], busy_v[g], data_v[g], sel_v[g], exp_data[g]);
    end
    @(posedge clk); #1;
    n_chk++;
    if (done_v[g] !== 1'b0 || busy_v[g] !== 1'b0 || data_v[g] !== exp_data[g]) begin
      n_fail++;
      $display("FAIL %s after: done=%b busy=%b data=%b, required done=0 busy=0 data=%b",
               nm, done_v[g], busy_v[g], data_v[g], exp_data[g]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    st  = 3'b000;
    for (int g = 0; g < 3; g++) begin
      in_v[g] = 4'hF;
      exp_data[g] = 4'h0;
`ifdef MUX_SCAN_MASK_EN
      mk_v[g] = 4'h0;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (sel_v[g] !== 2'd0 || busy_v[g] !== 1'b0 ||
          done_v[g] !== 1'b0 || data_v[g] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: sel=%b busy=%b done=%b data=%b, required all 0",
                 g, sel_v[g], busy_v[g], done_v[g], data_v[g]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_scan;
    run_scan(0, 4'b1101, 4'b0000, "full_s2");
  endtask

  task automatic test_settle1;
    run_scan(1, 4'b0110, 4'b0000, "settle1");
  endtask

  task automatic test_random;
    int         g;
    logic [3:0] v;
    logic [3:0] m;
    for (int i = 0; i < 8; i++) begin
      g = int'($urandom_range(0, 2));
      v = 4'($urandom_range(0, 15));
`ifdef MUX_SCAN_MASK_EN
      m = 4'($urandom_range(0, 15));
`else
      m = 4'b0000;
`endif
      run_scan(g, v, m, "random");
    end
  endtask

  task automatic test_reset_midscan;
    run_scan(0, 4'b1011, 4'b0000, "pre_reset");
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if (sel_v[0] !== 2'd1 || busy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_pre: sel=%b busy=%b, required sel=01 busy=1",
               sel_v[0], busy_v[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int g = 0; g < 3; g++) exp_data[g] = 4'h0;
    n_chk++;
    if (sel_v[0] !== 2'd0 || busy_v[0] !== 1'b0 ||
        done_v[0] !== 1'b0 || data_v[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL midscan_rst: sel=%b busy=%b done=%b data=%b, required all 0",
               sel_v[0], busy_v[0], done_v[0], data_v[0]);
    end
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      n_chk++;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midscan_idle t=%0d: done=%b busy=%b, required 0 0",
                 t, done_v[0], busy_v[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] v;
    logic [3:0] prev;
    v = 4'($urandom_range(0, 15));
    in_v[0] = v;
    st[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      prev = exp_data[0];
      @(posedge clk); #1;
      for (int t = 0; t < 8; t++) begin
        n_chk++;
        if (sel_v[0] !== 2'(t / 2) || busy_v[0] !== 1'b1 ||
            done_v[0] !== 1'b0 || data_v[0] !== prev) begin
          n_fail++;
          $display("FAIL b2b k=%0d t=%0d: sel=%b busy=%b done=%b data=%b, required sel=%0d busy=1 done=0 data=%b",
                   k, t, sel_v[0], busy_v[0], done_v[0], data_v[0], t / 2, prev);
        end
        @(posedge clk); #1;
      end
      exp_data[0] = v;
      n_chk++;
      if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || data_v[0] !== v) begin
        n_fail++;
        $display("FAIL b2b_done k=%0d: done=%b busy=%b data=%b, required done=1 busy=0 data=%b",
                 k, done_v[0], busy_v[0], data_v[0], v);
      end
      v = 4'($urandom_range(0, 15));
      in_v[0] = v;
      @(posedge clk); #1;
      if (k == 3) st[0] = 1'b0;
      n_chk++;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || sel_v[0] !== 2'd0) begin
        n_fail++;
        $display("FAIL b2b_idle k=%0d: done=%b busy=%b sel=%b, required 0 0 00",
                 k, done_v[0], busy_v[0], sel_v[0]);
      end
    end
    @(posedge clk); #1;
    n_chk++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: busy=%b done=%b, required 0 0",
               busy_v[0], done_v[0]);
    end
  endtask

`ifdef MUX_SCAN_MASK_EN
  task automatic test_mask;
    run_scan(2, 4'b1111, 4'b0101, "mask_0101");
    run_scan(2, 4'b1111, 4'b1111, "mask_1111");
    run_scan(0, 4'b0110, 4'b1000, "mask_1000");
    run_scan(1, 4'b1001, 4'b0110, "mask_0110");
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_settle1();
    test_random();
    test_reset_midscan();
    test_back_to_back();
`ifdef MUX_SCAN_MASK_EN
    test_mask();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
